// File: rtl/cba_pkg.sv
// rtl/cba_pkg.sv - shared types and elaboration helpers for the block-serial carry-bypass adder
package cba_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cba_state_t;

  // Number of bypass blocks, which is also the number of RUN cycles per operation.
  function automatic int cba_nblk(input int width, input int block);
    return width / block;
  endfunction

  // skip_cnt must be able to hold every value from 0 up to NBLK inclusive.
  function automatic int cba_cnt_w(input int width, input int block);
    return $clog2((width / block) + 1);
  endfunction

  // Legal only when BLOCK is non-zero and tiles WIDTH exactly.
  function automatic bit cba_params_ok(input int width, input int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/cba_block.sv
// rtl/cba_block.sv - combinational BLOCK-bit carry-bypass slice (CBA_OVF_EN adds msb_cin)
module cba_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             bypass
`ifdef CBA_OVF_EN
  ,
  output logic             msb_cin
`endif
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;

  // Ripple the slice from cin; when every bit propagates the bypass path forwards cin directly.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]   = p[i] ^ c[i];
      c[i+1]   = g[i] | (p[i] & c[i]);
    end
    bypass = &p;
    cout   = bypass ? cin : c[BLOCK];
  end

`ifdef CBA_OVF_EN
  assign msb_cin = c[BLOCK-1];
`endif

endmodule

// File: rtl/carry_bypass_adder_seq.sv
// rtl/carry_bypass_adder_seq.sv - block-serial carry-bypass adder, one slice per clock (CBA_OVF_EN adds ovf)
module carry_bypass_adder_seq
  import cba_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int BLOCK = 4,
  localparam int NBLK  = cba_nblk(WIDTH, BLOCK),
  localparam int CNT_W = cba_cnt_w(WIDTH, BLOCK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [CNT_W-1:0] skip_cnt
`ifdef CBA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  if (!cba_params_ok(WIDTH, BLOCK)) begin : g_bad_params
    $error("carry_bypass_adder_seq: WIDTH must be a positive multiple of BLOCK");
  end

  cba_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_w_q, a_w_d;
  logic [WIDTH-1:0] b_w_q, b_w_d;
  logic [WIDTH-1:0] sum_w_q, sum_w_d;
  logic             carry_w_q, carry_w_d;
  logic [CNT_W-1:0] skip_w_q, skip_w_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  logic [BLOCK-1:0] blk_a, blk_b, blk_sum;
  logic             blk_cout, blk_bypass;
  int               idx_int;
  logic             last_blk;

`ifdef CBA_OVF_EN
  logic ovf_q, ovf_d;
  logic blk_msb_cin;
`endif

  assign idx_int  = int'(idx_q);
  assign last_blk = (idx_q == IDX_W'(NBLK - 1));
  assign blk_a    = a_w_q[idx_int*BLOCK +: BLOCK];
  assign blk_b    = b_w_q[idx_int*BLOCK +: BLOCK];

  cba_block #(.BLOCK(BLOCK)) u_blk (
    .a      (blk_a),
    .b      (blk_b),
    .cin    (carry_w_q),
    .sum    (blk_sum),
    .cout   (blk_cout),
    .bypass (blk_bypass)
`ifdef CBA_OVF_EN
    ,
    .msb_cin(blk_msb_cin)
`endif
  );

  // Next-state and datapath: accept in IDLE/DONE, walk one slice per RUN cycle, publish on the last slice.
  always_comb begin
    state_d    = state_q;
    a_w_d      = a_w_q;
    b_w_d      = b_w_q;
    sum_w_d    = sum_w_q;
    carry_w_d  = carry_w_q;
    skip_w_d   = skip_w_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    skip_cnt_d = skip_cnt_q;
`ifdef CBA_OVF_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          a_w_d     = a;
          b_w_d     = b;
          carry_w_d = c_in;
          skip_w_d  = '0;
          sum_w_d   = '0;
          idx_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_w_d[idx_int*BLOCK +: BLOCK] = blk_sum;
        carry_w_d = blk_cout;
        skip_w_d  = skip_w_q + CNT_W'(blk_bypass);
        idx_d     = idx_q + IDX_W'(1);
        if (last_blk) begin
          state_d    = ST_DONE;
          idx_d      = '0;
          sum_d      = sum_w_d;
          c_out_d    = blk_cout;
          skip_cnt_d = skip_w_d;
`ifdef CBA_OVF_EN
          ovf_d      = blk_msb_cin ^ blk_cout;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_w_q      <= '0;
      b_w_q      <= '0;
      sum_w_q    <= '0;
      carry_w_q  <= 1'b0;
      skip_w_q   <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      skip_cnt_q <= '0;
`ifdef CBA_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_w_q      <= a_w_d;
      b_w_q      <= b_w_d;
      sum_w_q    <= sum_w_d;
      carry_w_q  <= carry_w_d;
      skip_w_q   <= skip_w_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      skip_cnt_q <= skip_cnt_d;
`ifdef CBA_OVF_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign skip_cnt = skip_cnt_q;
`ifdef CBA_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_carry_bypass_adder_seq.sv
// tb/tb_carry_bypass_adder_seq.sv - self-checking bench for carry_bypass_adder_seq (16/4 and 4/4 builds, CBA_OVF_EN aware)
module tb_carry_bypass_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic        busy, done, c_out;
  logic [15:0] sum;
  logic [2:0]  skip_cnt;
  logic        ovf;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        c_in4 = 1'b0;
  logic        busy4, done4, c_out4;
  logic [3:0]  sum4;
  logic [0:0]  skip_cnt4;
  logic        ovf4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  carry_bypass_adder_seq #(.WIDTH(16), .BLOCK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .skip_cnt(skip_cnt)
`ifdef CBA_OVF_EN
    , .ovf(ovf)
`endif
  );

  carry_bypass_adder_seq #(.WIDTH(4), .BLOCK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(c_in4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c_out4), .skip_cnt(skip_cnt4)
`ifdef CBA_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef CBA_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    int          sk;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition, bypass count from whole-slice propagate, sign-rule overflow.
  function automatic void model(input int w, input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                                output logic [15:0] s, output logic co, output int sk, output logic ov);
    logic [16:0] t;
    logic [15:0] x;
    logic [15:0] msk;
    msk = 16'((17'd1 << w) - 17'd1);
    t   = {1'b0, ma & msk} + {1'b0, mb & msk} + 17'(mc);
    s   = t[15:0] & msk;
    co  = t[w];
    x   = ma ^ mb;
    sk  = 0;
    for (int i = 0; i < w / 4; i++)
      if (((x >> (4 * i)) & 16'hF) == 16'hF) sk++;
    ov  = (ma[w-1] == mb[w-1]) && (s[w-1] != ma[w-1]);
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic launch16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check16(input string nm, input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input int lat);
    logic [15:0] s; logic co; int sk; logic ov;
    model(16, ta, tb_, tc, s, co, sk, ov);
    chk({nm, "_lat"}, 32'(lat), 32'd4);
    chk({nm, "_sum"}, 32'(sum), 32'(s));
    chk({nm, "_cout"}, 32'(c_out), 32'(co));
    chk({nm, "_skip"}, 32'(skip_cnt), 32'(sk));
`ifdef CBA_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(ov));
`endif
  endtask

  vec_t vt[7];

  initial begin
    int lat;
    int seen;
    logic [15:0] ra, rb;
    logic        rc;
    logic [15:0] s; logic co; int sk; logic ov;

    vt[0] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 4, 1'b0};
    vt[1] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 2, 1'b1};
    vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 1'b0};
    vt[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4, 1'b0};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(c_out), 0);
    chk("rst_skip", 32'(skip_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      launch16(vt[i].a, vt[i].b, vt[i].cin);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 1);
      wait_done(lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 4);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vt[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(c_out), 32'(vt[i].co));
      chk($sformatf("vec%0d_skip", i), 32'(skip_cnt), 32'(vt[i].sk));
`ifdef CBA_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
`endif
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 0);
    end

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;
      launch16(ra, rb, rc);
      wait_done(lat);
      check16($sformatf("rnd%0d", i), ra, rb, rc, lat);
    end

    // Start pulsed during RUN is ignored
    launch16(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    wait_done(seen);
    lat += seen;
    check16("run_start", 16'h1234, 16'h4321, 1'b0, lat);
    @(posedge clk); #1;
    chk("run_start_not_queued", 32'(busy), 0);

    // Back-to-back: start held through DONE
    launch16(16'h7FFF, 16'h0001, 1'b0);
    wait_done(lat);
    check16("b2b_first", 16'h7FFF, 16'h0001, 1'b0, lat);
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", 32'(busy), 1);
    wait_done(lat);
    check16("b2b_second", 16'hFFFF, 16'hFFFF, 1'b1, lat);

    // Reset during block 2 aborts
    launch16(16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(c_out), 0);
    chk("abort_skip", 32'(skip_cnt), 0);
    chk("abort_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);
    launch16(16'h00FF, 16'hFF00, 1'b1);
    wait_done(lat);
    check16("after_abort", 16'h00FF, 16'hFF00, 1'b1, lat);

    // NBLK=1 build: latency 1
    @(negedge clk);
    a4 = 4'b1110; b4 = 4'b0101; c_in4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("w4_busy", 32'(busy4), 1);
    @(posedge clk); #1;
    chk("w4_done", 32'(done4), 1);
    chk("w4_sum", 32'(sum4), 32'h4);
    chk("w4_cout", 32'(c_out4), 1);
    chk("w4_skip", 32'(skip_cnt4), 0);
    chk("w4_ovf", 32'(ovf4), 0);
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15)); rc = 1'($urandom);
      if (i % 4 == 0) rb = ra ^ 16'hF;
      model(4, ra, rb, rc, s, co, sk, ov);
      @(negedge clk);
      a4 = ra[3:0]; b4 = rb[3:0]; c_in4 = rc; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("w4r%0d_done", i), 32'(done4), 1);
      chk($sformatf("w4r%0d_sum", i), 32'(sum4), 32'(s[3:0]));
      chk($sformatf("w4r%0d_cout", i), 32'(c_out4), 32'(co));
      chk($sformatf("w4r%0d_skip", i), 32'(skip_cnt4), 32'(sk));
`ifdef CBA_OVF_EN
      chk($sformatf("w4r%0d_ovf", i), 32'(ovf4), 32'(ov));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carry_bypass_adder_seq.md
# carry_bypass_adder_seq

Parametrised, block-serial carry-bypass adder: adds two WIDTH-bit operands plus carry-in, one BLOCK-bit slice per clock, with a start/busy/done handshake. Each slice uses bypass logic: if every bit of the slice propagates, the slice carry-out is the slice carry-in and the event is counted. It succeeds the fixed 4-bit combinational carry-bypass adder in the adder library and is the ALU's area-reduced wide adder for multi-cycle datapaths.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 4, bits per bypass block; must be at least 1.
- NBLK, derived as WIDTH/BLOCK, number of blocks and the cycles per operation.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- c_in  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results are valid and updated.
- sum  output  WIDTH  result; holds its value until the next done.
- c_out  output  1  final carry; holds its value until the next done.
- skip_cnt  output  $clog2(NBLK+1)  number of bypassed blocks in the last operation.
- ovf  output  1  two's-complement overflow; present only with CBA_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN.
  - RUN: stays in RUN until the last block is committed, then → DONE.
  - DONE: start=1 → RUN; otherwise → IDLE.
- Accepting start captures a, b and c_in into working registers, sets block index to 0, sets the working carry to c_in and clears the working skip count.
- Each RUN cycle processes block i (bits i*BLOCK+BLOCK-1 .. i*BLOCK):
  - Compute P = a^b and G = a&b on the slice.
  - Compute the ripple sum from the working carry.
  - If &P is true, the next carry is the working carry (bypass) and the skip count increments.
  - Otherwise the next carry is the ripple carry-out.
- The sum slice is written into the working sum register.
- Committing the last block (i = NBLK-1) copies the working sum, final carry and skip count to sum, c_out and skip_cnt, and asserts done.
- start in RUN is ignored; it is not queued.
- All arithmetic is modulo 2^WIDTH. {c_out, sum} equals a + b + c_in exactly.

## Timing
- Reset values: state IDLE; busy=0, done=0, sum=0, c_out=0, skip_cnt=0, ovf=0; all working registers 0.
- Start accepted at edge E0. busy is high from after E0 through edge E_NBLK.
- Block i is committed at edge E(i+1).
- done is high for exactly the one cycle after E_NBLK. Latency is NBLK cycles from the start edge to done.
- Back-to-back: start held high during the DONE cycle is accepted, so throughput is one operation per NBLK+1 cycles.
- Reset asserted mid-operation aborts immediately: no done pulse, all outputs return to reset values.
- NBLK=1 (WIDTH=BLOCK): single RUN cycle, latency 1.

## Configuration
- CBA_OVF_EN defined:
  - The ovf port exists.
  - At the final commit it registers carry-into-MSB XOR carry-out-of-MSB, where carry-out-of-MSB is the post-bypass c_out.
  - It is updated with sum and cleared by reset.
- CBA_OVF_EN undefined: no ovf port and no MSB-carry tracking logic.

## Structure
- Package cba_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the function computing NBLK and the skip_cnt width;
  - a parameter-legality check (WIDTH % BLOCK == 0).
- Sub-module cba_block: combinational BLOCK-bit slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout (post-bypass), bypass flag, msb carry-in.
  - It is instantiated once and reused every cycle through a slice mux.

## Test plan
- WIDTH=16, BLOCK=4: a=0x00FF, b=0xFF00, c_in=1 → sum=0x0000, c_out=1, skip_cnt=4; done exactly 4 cycles after start.
- a=0x1234, b=0x4321, c_in=0 → sum=0x5555, c_out=0, skip_cnt=0.
- a=0x7FFF, b=0x0001, c_in=0 → sum=0x8000, c_out=0, skip_cnt=2; with CBA_OVF_EN, ovf=1.
- WIDTH=4, BLOCK=4: a=1110, b=0101, c_in=1 → sum=0100, c_out=1, skip_cnt=0, latency 1.
- Protocol, two checks:
  - Pulse start again during RUN: it is ignored and the result is unchanged.
  - Hold start high through DONE with a=0xFFFF, b=0xFFFF, c_in=1: the second operation starts immediately and gives sum=0xFFFF, c_out=1.
- Drop rst_n for one cycle during block 2 → outputs all 0, no done, state IDLE; a subsequent operation is correct.
